// File: rtl/uart_tx_responder_if.sv
// Bundle between the load/store unit and the UART TX responder.
//
// Push semantics: byte_ready_i is a one-cycle strobe qualified by uart_on_i;
// data_in is captured at the rising edge where both are high and full_o is
// low. There is no ready/back-pressure path: a strobe that arrives while
// full_o is high is dropped and latched into the sticky ovf_o flag.
// fsm_state exposes the transmitter state encoding for observation.
interface uart_tx_responder_if;
    logic       byte_ready_i;
    logic       uart_on_i;
    logic [7:0] data_in;
    logic       tx_o;
    logic       busy_o;
    logic       full_o;
    logic       tx_done_o;
    logic       ovf_o;
    logic [2:0] fsm_state;

    modport master (
        output byte_ready_i, uart_on_i, data_in,
        input  tx_o, busy_o, full_o, tx_done_o, ovf_o, fsm_state
    );

    modport slave (
        input  byte_ready_i, uart_on_i, data_in,
        output tx_o, busy_o, full_o, tx_done_o, ovf_o, fsm_state
    );
endinterface

// File: rtl/uart_tx_responder.sv
// UART TX responder: buffers bytes stored to the UART window in a small FIFO
// and serialises them as 8N1 frames, LSB first, on tx_o.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between the
// data bits and the stop bit (8E1 framing).
module uart_tx_responder #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DEPTH        = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_tx_responder_if.slave   bus
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_q;
    logic             busy_q;
    logic             ovf_q;

    // Transmitter state
    state_t           state_q;
    state_t           state_d;
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]       bit_idx_q;
    logic [2:0]       bit_idx_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
    logic             parity_d;
`endif

    logic push_req;
    logic push;
    logic pop;
    logic baud_tc;
    logic tx;
    logic tx_done;

    // A strobe counts only when the UART window is selected; full_q is the
    // pre-edge view, so a push while full is dropped even if a pop happens.
    assign push_req = bus.byte_ready_i & bus.uart_on_i;
    assign push     = push_req & ~full_q;
    assign baud_tc  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    // Occupancy after this edge's push and pop
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO write port; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // FIFO pointers, occupancy and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            busy_q  <= (state_d != IDLE) || (count_d != '0);
            ovf_q   <= ovf_q | (push_req & full_q);
        end
    end

    // Transmitter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Frame sequencing: next state, baud/bit counters, line level, pop and done
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        pop       = 1'b0;
        tx        = 1'b1;
        tx_done   = 1'b0;

        case (state_q)
            IDLE: begin
                tx = 1'b1;
                if (count_q != '0) begin
                    pop       = 1'b1;
                    shift_d   = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^mem[rd_ptr];
`endif
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (baud_tc) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                tx = shift_q[0];
                if (baud_tc) begin
                    baud_d    = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx = parity_q;
                if (baud_tc) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            STOP: begin
                tx = 1'b1;
                if (baud_tc) begin
                    baud_d  = '0;
                    tx_done = 1'b1;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // tx_o decodes from reset-cleared state, so a reset forces the line high at once
    assign bus.tx_o      = tx;
    assign bus.tx_done_o = tx_done;
    assign bus.busy_o    = busy_q;
    assign bus.full_o    = full_q;
    assign bus.ovf_o     = ovf_q;
    assign bus.fsm_state = state_q;

endmodule
